// File: rtl/uart_rx_ext.sv
// UART receiver with run-time frame format (5-8 data bits, optional parity, 1/2 stop bits),
// 3-sample majority voting and a valid/ready receive FIFO carrying per-character error flags.
module uart_rx_ext #(
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic             i_Clock,
    input  logic             rst_i,
    input  logic             i_Rx_Serial,
    input  logic [CNT_W-1:0] i_Clks_Per_Bit,
    input  logic [1:0]       i_Data_Bits,
    input  logic             i_Parity_En,
    input  logic             i_Parity_Odd,
    input  logic             i_Two_Stop,
    input  logic             i_Rx_Ready,
    input  logic             i_Clear_Err,
    output logic             o_Rx_Valid,
    output logic [7:0]       o_Rx_Byte,
    output logic             o_Frame_Err,
    output logic             o_Parity_Err,
    output logic             o_Overflow,
    output logic             o_Break,
    output logic             o_Busy,
    output logic [PTR_W:0]   o_Fifo_Count
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_IDLE
    } state_t;

    function automatic logic majority3(input logic [2:0] h);
        return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
    endfunction

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    logic             rx_sync_p0, rx_sync_p1;
    logic [2:0]       hist_p2;
    state_t           state;
    logic [CNT_W-1:0] cnt, cpb_q;
    logic [1:0]       nbits_q;
    logic             par_en_q, par_odd_q, two_stop_q;
    logic [2:0]       idx;
    logic [7:0]       data_q;
    logic             par_bit_q, par_err_q;
    logic             bit_maj, sample_full, start_det;
    logic [CNT_W-1:0] half_cnt;
    logic [2:0]       last_idx;
    logic             push, push_ferr, push_brk;

    logic [9:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fifo_cnt;
    logic             fifo_full, fifo_empty, pop, wr_en;
    logic             ovf_q, brk_q;
    logic [9:0]       head;

    // Stage p0/p1: two-flop synchroniser; p2: majority history
    always_ff @(posedge i_Clock or posedge rst_i) begin
        if (rst_i) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            hist_p2    <= 3'b111;
        end else begin
            rx_sync_p0 <= i_Rx_Serial;
            rx_sync_p1 <= rx_sync_p0;
            hist_p2    <= {hist_p2[1:0], rx_sync_p1};
        end
    end

    assign bit_maj     = majority3(hist_p2);
    assign half_cnt    = (cpb_q - CNT_W'(1)) >> 1;
    assign sample_full = (cnt == cpb_q - CNT_W'(1));
    assign last_idx    = 3'd4 + {1'b0, nbits_q};
    assign start_det   = (state == S_IDLE) && !rx_sync_p1;

    // The character is pushed in the same cycle as the final stop-bit sample.
    always_comb begin
        push      = 1'b0;
        push_ferr = 1'b0;
        if (sample_full) begin
            if (state == S_STOP1 && !(two_stop_q && bit_maj)) begin
                push      = 1'b1;
                push_ferr = !bit_maj;
            end else if (state == S_STOP2) begin
                push      = 1'b1;
                push_ferr = !bit_maj;
            end
        end
        push_brk = push && push_ferr && (data_q == 8'h00) && !(par_en_q && par_bit_q);
    end

    always_ff @(posedge i_Clock or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cpb_q      <= CNT_W'(4);
            nbits_q    <= 2'b11;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            idx        <= 3'd0;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start_det) begin
                    state      <= S_START;
                    cnt        <= '0;
                    cpb_q      <= (i_Clks_Per_Bit < CNT_W'(4)) ? CNT_W'(4) : i_Clks_Per_Bit;
                    nbits_q    <= i_Data_Bits;
                    par_en_q   <= i_Parity_En;
                    par_odd_q  <= i_Parity_Odd;
                    two_stop_q <= i_Two_Stop;
                    idx        <= 3'd0;
                    par_bit_q  <= 1'b0;
                    par_err_q  <= 1'b0;
                end
                S_START: if (cnt == half_cnt) begin
                    cnt   <= '0;
                    state <= bit_maj ? S_IDLE : S_DATA;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                S_DATA: if (sample_full) begin
                    cnt <= '0;
                    if (idx == last_idx) state <= par_en_q ? S_PARITY : S_STOP1;
                    else                 idx   <= idx + 3'd1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                S_PARITY: if (sample_full) begin
                    cnt       <= '0;
                    par_bit_q <= bit_maj;
                    par_err_q <= (^data_q) ^ bit_maj ^ par_odd_q;
                    state     <= S_STOP1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                S_STOP1: if (sample_full) begin
                    cnt <= '0;
                    if (two_stop_q && bit_maj) state <= S_STOP2;
                    else                       state <= bit_maj ? S_IDLE : S_WAIT_IDLE;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                S_STOP2: if (sample_full) begin
                    cnt   <= '0;
                    state <= bit_maj ? S_IDLE : S_WAIT_IDLE;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                S_WAIT_IDLE: if (rx_sync_p1) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Data shift register; cleared at frame start so unused upper bits read 0
    always_ff @(posedge i_Clock) begin
        if (start_det)                        data_q      <= 8'h00;
        else if (state == S_DATA && sample_full) data_q[idx] <= bit_maj;
    end

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == DEPTH_C);
    assign pop        = !fifo_empty && i_Rx_Ready;
    assign wr_en      = push && (!fifo_full || pop);

    always_ff @(posedge i_Clock) begin
        if (wr_en) fifo_mem[wr_ptr] <= {par_err_q, push_ferr, data_q};
    end

    always_ff @(posedge i_Clock or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ovf_q    <= 1'b0;
            brk_q    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push && fifo_full && !pop) ovf_q <= 1'b1;
            else if (i_Clear_Err)          ovf_q <= 1'b0;
            brk_q <= push_brk;
        end
    end

    assign head         = fifo_mem[rd_ptr];
    assign o_Rx_Valid   = !fifo_empty;
    assign o_Rx_Byte    = fifo_empty ? 8'h00 : head[7:0];
    assign o_Frame_Err  = !fifo_empty && head[8];
    assign o_Parity_Err = !fifo_empty && head[9];
    assign o_Overflow   = ovf_q;
    assign o_Break      = brk_q;
    assign o_Busy       = (state != S_IDLE);
    assign o_Fifo_Count = fifo_cnt;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: table of frame formats plus hand-written
// sequences for framing errors, break, overflow, glitches and mid-frame reset.
module tb_uart_rx_ext;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic [15:0] cpb = 16'(CPB);
    logic [1:0]  data_bits = 2'b11;
    logic        par_en = 1'b0, par_odd = 1'b0, two_stop = 1'b0;
    logic        rdy = 1'b0, clr = 1'b0;
    logic        valid, ferr, perr, ovf, brk, busy;
    logic [7:0]  rbyte;
    logic [2:0]  fcnt;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_ext #(.CNT_W(16), .FIFO_DEPTH(4)) dut (
        .i_Clock(clk), .rst_i(rst), .i_Rx_Serial(rx), .i_Clks_Per_Bit(cpb),
        .i_Data_Bits(data_bits), .i_Parity_En(par_en), .i_Parity_Odd(par_odd),
        .i_Two_Stop(two_stop), .i_Rx_Ready(rdy), .i_Clear_Err(clr),
        .o_Rx_Valid(valid), .o_Rx_Byte(rbyte), .o_Frame_Err(ferr),
        .o_Parity_Err(perr), .o_Overflow(ovf), .o_Break(brk), .o_Busy(busy),
        .o_Fifo_Count(fcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         nb;
        logic       pen, podd, pbit, two, st1, st2;
        logic [7:0] eb;
        logic       ef, ep;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_bit(input logic v, input logic glitch);
        rx = v;
        if (glitch) begin
            repeat (8) @(negedge clk);
            rx = ~v;
            @(negedge clk);
            rx = v;
            repeat (CPB - 9) @(negedge clk);
        end else begin
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic pen, input logic pbit,
                              input logic two, input logic st1, input logic st2, input int gl_bit);
        send_bit(1'b0, 1'b0);
        for (int b = 0; b < nb; b++) send_bit(d[b], gl_bit == b);
        if (pen) send_bit(pbit, 1'b0);
        send_bit(st1, 1'b0);
        if (two) send_bit(st2, 1'b0);
    endtask

    task automatic set_cfg(input int nb, input logic pen, input logic podd, input logic two);
        data_bits = 2'(nb - 5);
        par_en    = pen;
        par_odd   = podd;
        two_stop  = two;
    endtask

    task automatic pop_one();
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_byte"},  32'(rbyte), 32'd0);
        check({tag, "_ferr"},  32'(ferr),  32'd0);
        check({tag, "_perr"},  32'(perr),  32'd0);
        check({tag, "_ovf"},   32'(ovf),   32'd0);
        check({tag, "_brk"},   32'(brk),   32'd0);
        check({tag, "_busy"},  32'(busy),  32'd0);
        check({tag, "_count"}, 32'(fcnt),  32'd0);
    endtask

    initial begin
        int brk_cnt;

        vecs[0] = '{8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h35, 1'b0, 1'b1};
        vecs[2] = '{8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h35, 1'b0, 1'b0};
        vecs[3] = '{8'h15, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h15, 1'b0, 1'b0};
        vecs[4] = '{8'h2A, 6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0};
        vecs[5] = '{8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle_bits(1);

        for (int i = 0; i < 6; i++) begin
            set_cfg(vecs[i].nb, vecs[i].pen, vecs[i].podd, vecs[i].two);
            send_frame(vecs[i].d, vecs[i].nb, vecs[i].pen, vecs[i].pbit,
                       vecs[i].two, vecs[i].st1, vecs[i].st2, -1);
            idle_bits(2);
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'd1);
            check($sformatf("vec%0d_byte", i),  32'(rbyte), 32'(vecs[i].eb));
            check($sformatf("vec%0d_ferr", i),  32'(ferr),  32'(vecs[i].ef));
            check($sformatf("vec%0d_perr", i),  32'(perr),  32'(vecs[i].ep));
            check($sformatf("vec%0d_count", i), 32'(fcnt),  32'd1);
            check($sformatf("vec%0d_busy", i),  32'(busy),  32'd0);
            pop_one();
            check($sformatf("vec%0d_popped", i), 32'(valid), 32'd0);
        end

        // 8N2 with bad second stop bit, line then held low
        set_cfg(8, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("stop2_byte",  32'(rbyte), 32'h3C);
        check("stop2_ferr",  32'(ferr),  32'd1);
        check("stop2_wait_busy", 32'(busy), 32'd1);
        check("stop2_wait_count", 32'(fcnt), 32'd1);
        idle_bits(2);
        check("stop2_idle_busy", 32'(busy), 32'd0);
        pop_one();
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1);
        idle_bits(2);
        check("after_ferr_byte", 32'(rbyte), 32'h81);
        check("after_ferr_ferr", 32'(ferr),  32'd0);
        check("after_ferr_count", 32'(fcnt), 32'd1);
        pop_one();

        // Break: line low for 12 bit times, 8N1
        set_cfg(8, 1'b0, 1'b0, 1'b0);
        brk_cnt = 0;
        rx = 1'b0;
        for (int c = 0; c < 12 * CPB; c++) begin
            @(negedge clk);
            if (brk) brk_cnt++;
        end
        check("break_pulses", 32'(brk_cnt), 32'd1);
        check("break_byte",   32'(rbyte),   32'h00);
        check("break_ferr",   32'(ferr),    32'd1);
        check("break_valid",  32'(valid),   32'd1);
        check("break_busy",   32'(busy),    32'd1);
        idle_bits(2);
        check("break_count",  32'(fcnt),    32'd1);
        check("break_idle",   32'(busy),    32'd0);
        pop_one();

        // Overflow: five characters into a four-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
            idle_bits(1);
        end
        check("ovf_count", 32'(fcnt), 32'd4);
        check("ovf_flag",  32'(ovf),  32'd1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain%0d", i), 32'(rbyte), 32'(i));
            pop_one();
        end
        check("drain_empty", 32'(valid), 32'd0);
        check("ovf_sticky",  32'(ovf),   32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);

        // One-cycle low pulse on an idle line
        rx = 1'b0;
        @(negedge clk);
        idle_bits(2);
        check("idle_glitch_count", 32'(fcnt), 32'd0);
        check("idle_glitch_busy",  32'(busy), 32'd0);

        // Single-cycle inverted glitch at data bit 2 centre
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        idle_bits(2);
        check("bit_glitch_byte",  32'(rbyte), 32'hA5);
        check("bit_glitch_ferr",  32'(ferr),  32'd0);
        check("bit_glitch_count", 32'(fcnt),  32'd1);

        // Reset during data bit 3 with one character already queued
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_bits(2);
        check_reset_outputs("postrst");
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle_bits(2);
        check("postrst_frame_byte",  32'(rbyte), 32'h5A);
        check("postrst_frame_count", 32'(fcnt),  32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
